food_spawn_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 37 +++
 rtl/grid_snap.sv | 34 +++
 rtl/food_spawn_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_food_spawn_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game food placement logic: the food
// spawn state encoding, screen/grid geometry and coordinate widths.
package snake_pkg;

   // Food spawn sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      QUERY  = 3'd2,
      COMMIT = 3'd3,
      FAIL   = 3'd4
   } state_t;

   // Cell size and legal food area, all in pixels
   localparam int GRID  = 20;
   localparam int X_MIN = 20;
   localparam int X_MAX = 600;
   localparam int Y_MIN = 20;
   localparam int Y_MAX = 440;

   // Coordinate widths: 10 bits covers 640 columns, 9 bits covers 480 rows
   localparam int X_W = 10;
   localparam int Y_W = 9;

   // Retry budget and the counter width that holds up to 15 tries
   localparam int MAX_TRIES = 8;
   localparam int TRY_W     = 4;

   // Food position shown right after reset
   localparam int INIT_X = 300;
   localparam int INIT_Y = 200;

   // Query watchdog: counter width and the last count before giving up
   localparam int WDOG_W    = 4;
   localparam int WDOG_LAST = 14;

endpackage

// File: rtl/grid_snap.sv
// Snaps one raw random coordinate down to the cell grid and clamps it to
// the legal food range for that axis. Purely combinational; one instance
// per axis.
module grid_snap #(
   parameter int W    = 10,
   parameter int GRID = 20,
   parameter int MIN  = 20,
   parameter int MAX  = 600
) (
   input  logic [W-1:0] raw,
   output logic [W-1:0] snapped
);

   localparam logic [W-1:0] GRID_V = W'(GRID);
   localparam logic [W-1:0] MIN_V  = W'(MIN);
   localparam logic [W-1:0] MAX_V  = W'(MAX);

   logic [W-1:0] quot;
   logic [W-1:0] prod;

   // Round down to a grid multiple, then pull into [MIN, MAX]
   always_comb begin
      quot = raw / GRID_V;
      prod = quot * GRID_V;
      if (prod < MIN_V) begin
         snapped = MIN_V;
      end else if (prod > MAX_V) begin
         snapped = MAX_V;
      end else begin
         snapped = prod;
      end
   end

endmodule

// File: rtl/food_spawn_ctrl.sv
// Food spawn sequencer for the snake game. On a spawn request it samples
// the upstream random coordinates, snaps them to the grid, asks the
// snake-body occupancy checker whether the cell is free and retries up to
// MAX_TRIES times before committing the last cell anyway.
//
// Optional build macro FOOD_QUERY_TIMEOUT_EN: adds a watchdog that treats
// a query left unanswered for 15 cycles as a free cell.
module food_spawn_ctrl
   import snake_pkg::*;
#(
   parameter int GRID      = snake_pkg::GRID,
   parameter int X_MIN     = snake_pkg::X_MIN,
   parameter int X_MAX     = snake_pkg::X_MAX,
   parameter int Y_MIN     = snake_pkg::Y_MIN,
   parameter int Y_MAX     = snake_pkg::Y_MAX,
   parameter int MAX_TRIES = snake_pkg::MAX_TRIES,
   parameter int INIT_X    = snake_pkg::INIT_X,
   parameter int INIT_Y    = snake_pkg::INIT_Y
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           spawn_req,
   input  logic [X_W-1:0] rand_x,
   input  logic [Y_W-1:0] rand_y,
   output logic           occ_req,
   output logic [X_W-1:0] occ_x,
   output logic [Y_W-1:0] occ_y,
   input  logic           occ_ack,
   input  logic           occ_hit,
   output logic [X_W-1:0] food_x,
   output logic [Y_W-1:0] food_y,
   output logic           food_valid,
   output logic           busy,
   output logic           spawn_done,
   output logic           spawn_fail
);

   localparam logic [X_W-1:0]   INIT_X_V    = X_W'(INIT_X);
   localparam logic [Y_W-1:0]   INIT_Y_V    = Y_W'(INIT_Y);
   localparam logic [TRY_W-1:0] MAX_TRIES_V = TRY_W'(MAX_TRIES);

   logic [X_W-1:0] snap_x;
   logic [Y_W-1:0] snap_y;

   state_t           state_q,      state_d;
   logic [TRY_W-1:0] tries_q,      tries_d;
   logic             occ_req_q,    occ_req_d;
   logic [X_W-1:0]   occ_x_q,      occ_x_d;
   logic [Y_W-1:0]   occ_y_q,      occ_y_d;
   logic [X_W-1:0]   food_x_q,     food_x_d;
   logic [Y_W-1:0]   food_y_q,     food_y_d;
   logic             food_valid_q, food_valid_d;
   logic             busy_q,       busy_d;
   logic             spawn_done_q, spawn_done_d;
   logic             spawn_fail_q, spawn_fail_d;
`ifdef FOOD_QUERY_TIMEOUT_EN
   logic [WDOG_W-1:0] wdog_q,      wdog_d;
`endif

   grid_snap #(
      .W    (X_W),
      .GRID (GRID),
      .MIN  (X_MIN),
      .MAX  (X_MAX)
   ) u_snap_x (
      .raw     (rand_x),
      .snapped (snap_x)
   );

   grid_snap #(
      .W    (Y_W),
      .GRID (GRID),
      .MIN  (Y_MIN),
      .MAX  (Y_MAX)
   ) u_snap_y (
      .raw     (rand_y),
      .snapped (snap_y)
   );

   // Next-state and register-update logic for the spawn sequence
   always_comb begin
      state_d      = state_q;
      tries_d      = tries_q;
      occ_req_d    = occ_req_q;
      occ_x_d      = occ_x_q;
      occ_y_d      = occ_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      busy_d       = busy_q;
      spawn_done_d = 1'b0;
      spawn_fail_d = 1'b0;
`ifdef FOOD_QUERY_TIMEOUT_EN
      wdog_d       = wdog_q;
`endif

      case (state_q)
         IDLE: begin
            if (spawn_req) begin
               state_d      = SAMPLE;
               food_valid_d = 1'b0;
               busy_d       = 1'b1;
            end
         end

         SAMPLE: begin
            occ_x_d   = snap_x;
            occ_y_d   = snap_y;
            occ_req_d = 1'b1;
            tries_d   = tries_q + 1'b1;
`ifdef FOOD_QUERY_TIMEOUT_EN
            wdog_d    = '0;
`endif
            state_d   = QUERY;
         end

         QUERY: begin
            if (occ_ack) begin
               occ_req_d = 1'b0;
               if (!occ_hit) begin
                  state_d = COMMIT;
               end else if (tries_q < MAX_TRIES_V) begin
                  state_d = SAMPLE;
               end else begin
                  state_d = FAIL;
               end
`ifdef FOOD_QUERY_TIMEOUT_EN
            end else if (wdog_q == WDOG_W'(WDOG_LAST)) begin
               occ_req_d = 1'b0;
               state_d   = COMMIT;
            end else begin
               wdog_d = wdog_q + 1'b1;
`endif
            end
         end

         COMMIT: begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            spawn_done_d = 1'b1;
            busy_d       = 1'b0;
            tries_d      = '0;
            state_d      = IDLE;
         end

         FAIL: begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            spawn_done_d = 1'b1;
            spawn_fail_d = 1'b1;
            busy_d       = 1'b0;
            tries_d      = '0;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tries_q      <= '0;
         occ_req_q    <= 1'b0;
         occ_x_q      <= '0;
         occ_y_q      <= '0;
         food_x_q     <= INIT_X_V;
         food_y_q     <= INIT_Y_V;
         food_valid_q <= 1'b1;
         busy_q       <= 1'b0;
         spawn_done_q <= 1'b0;
         spawn_fail_q <= 1'b0;
`ifdef FOOD_QUERY_TIMEOUT_EN
         wdog_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tries_q      <= tries_d;
         occ_req_q    <= occ_req_d;
         occ_x_q      <= occ_x_d;
         occ_y_q      <= occ_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         busy_q       <= busy_d;
         spawn_done_q <= spawn_done_d;
         spawn_fail_q <= spawn_fail_d;
`ifdef FOOD_QUERY_TIMEOUT_EN
         wdog_q       <= wdog_d;
`endif
      end
   end

   assign occ_req    = occ_req_q;
   assign occ_x      = occ_x_q;
   assign occ_y      = occ_y_q;
   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign busy       = busy_q;
   assign spawn_done = spawn_done_q;
   assign spawn_fail = spawn_fail_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Scoreboard bench for food_spawn_ctrl. Stimulus pushes the expected
// spawn outcome; a monitor pops and compares whenever spawn_done pulses.
// A behavioural occupancy checker answers queries with a programmable
// number of hits and answer delay.
module tb_food_spawn_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       spawn_req;
   logic [9:0] rand_x;
   logic [8:0] rand_y;
   logic       occ_req;
   logic [9:0] occ_x;
   logic [8:0] occ_y;
   logic       occ_ack;
   logic       occ_hit;
   logic [9:0] food_x;
   logic [8:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       spawn_done;
   logic       spawn_fail;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int x;
      int y;
      int fail;
      int hs;
      int lat;
      int issue;
   } exp_t;

   exp_t sbQueue[$];

   bit respEn    = 1'b1;
   int respDelay = 0;
   int hitBudget = 0;
   int waitCnt   = 0;
   int hsCount   = 0;

   food_spawn_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .spawn_req  (spawn_req),
      .rand_x     (rand_x),
      .rand_y     (rand_y),
      .occ_req    (occ_req),
      .occ_x      (occ_x),
      .occ_y      (occ_y),
      .occ_ack    (occ_ack),
      .occ_hit    (occ_hit),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .busy       (busy),
      .spawn_done (spawn_done),
      .spawn_fail (spawn_fail)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Occupancy checker model: single-cycle ack, hits while budget lasts
   always @(posedge clk) begin
      #1;
      if (rst) begin
         occ_ack = 1'b0;
         waitCnt = 0;
      end else if (occ_ack) begin
         occ_ack = 1'b0;
      end else if (occ_req && respEn) begin
         if (waitCnt < respDelay) begin
            waitCnt++;
         end else begin
            waitCnt = 0;
            occ_ack = 1'b1;
            occ_hit = (hitBudget > 0);
            if (hitBudget > 0) hitBudget--;
         end
      end
   end

   // Monitor: count handshakes, score every completed spawn
   always @(negedge clk) begin
      if (rst) begin
         hsCount = 0;
      end else begin
         if (occ_req && occ_ack) begin
            hsCount++;
            if (sbQueue.size() > 0) begin
               checkOutput("query_x", int'(occ_x), sbQueue[0].x);
               checkOutput("query_y", int'(occ_y), sbQueue[0].y);
            end
         end
         if (spawn_fail && !spawn_done) begin
            checkOutput("fail_with_done", int'(spawn_done), 1);
         end
         if (spawn_done) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sbQueue.pop_front();
               checkOutput("food_x", int'(food_x), e.x);
               checkOutput("food_y", int'(food_y), e.y);
               checkOutput("food_valid", int'(food_valid), 1);
               checkOutput("busy_at_done", int'(busy), 0);
               checkOutput("spawn_fail", int'(spawn_fail), e.fail);
               checkOutput("handshakes", hsCount, e.hs);
               if (e.lat >= 0) checkOutput("latency", cyc - e.issue, e.lat);
            end
            hsCount = 0;
         end
      end
   end

   // Issue one spawn, push its expected outcome and wait (bounded) for it
   task automatic applyStimulus(input int rx, input int ry, input int hits, input int delay,
                                input int ex, input int ey, input int efail, input int ehs,
                                input int elat, input bit dupReq);
      exp_t e;
      int n;
      stepCycle();
      rand_x    = 10'(rx);
      rand_y    = 9'(ry);
      hitBudget = hits;
      respDelay = delay;
      e.x = ex; e.y = ey; e.fail = efail; e.hs = ehs; e.lat = elat; e.issue = cyc + 1;
      sbQueue.push_back(e);
      spawn_req = 1'b1;
      stepCycle();
      spawn_req = 1'b0;
      @(negedge clk);
      checkOutput("busy_after_req", int'(busy), 1);
      checkOutput("valid_after_req", int'(food_valid), 0);
      if (dupReq) begin
         stepCycle();
         spawn_req = 1'b1;
         stepCycle();
         spawn_req = 1'b0;
      end
      n = 0;
      while (sbQueue.size() != 0 && n < 200) begin
         stepCycle();
         n++;
      end
      checkOutput("spawn_completed", sbQueue.size(), 0);
      sbQueue.delete();
      repeat (10) stepCycle();
      @(negedge clk);
      checkOutput("idle_busy", int'(busy), 0);
   endtask

   // Global time limit so the bench always terminates
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      rst       = 1'b1;
      spawn_req = 1'b0;
      rand_x    = '0;
      rand_y    = '0;
      occ_ack   = 1'b0;
      occ_hit   = 1'b0;

      repeat (3) stepCycle();
      @(negedge clk);
      checkOutput("rst_food_x", int'(food_x), 300);
      checkOutput("rst_food_y", int'(food_y), 200);
      checkOutput("rst_food_valid", int'(food_valid), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_occ_req", int'(occ_req), 0);
      checkOutput("rst_occ_x", int'(occ_x), 0);
      checkOutput("rst_spawn_done", int'(spawn_done), 0);
      checkOutput("rst_spawn_fail", int'(spawn_fail), 0);
      stepCycle();
      rst = 1'b0;

      // Basic snap, zero-wait free answer, minimum latency
      applyStimulus(347, 133, 0, 0, 340, 120, 0, 1, 3, 1'b0);
      // Clamp both axes
      applyStimulus(1023, 5, 0, 0, 600, 20, 0, 1, 3, 1'b0);
      // Three hits then free
      applyStimulus(455, 301, 3, 0, 440, 300, 0, 4, 9, 1'b0);
      // Always occupied: retry budget exhausted
      applyStimulus(59, 479, 100, 0, 40, 440, 1, 8, 17, 1'b0);
      // Slow checker plus a spawn request while busy that must be dropped
      applyStimulus(10, 10, 0, 2, 20, 20, 0, 1, 5, 1'b1);

      // Reset in the middle of an unanswered query
      respEn = 1'b0;
      stepCycle();
      rand_x    = 10'd347;
      rand_y    = 9'd133;
      spawn_req = 1'b1;
      stepCycle();
      spawn_req = 1'b0;
      n = 0;
      while (!occ_req && n < 20) begin
         stepCycle();
         n++;
      end
      repeat (3) stepCycle();
      @(negedge clk);
      checkOutput("held_occ_req", int'(occ_req), 1);
      checkOutput("held_occ_x", int'(occ_x), 340);
      checkOutput("held_occ_y", int'(occ_y), 120);
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_occ_req", int'(occ_req), 0);
      checkOutput("midrst_food_x", int'(food_x), 300);
      checkOutput("midrst_food_y", int'(food_y), 200);
      checkOutput("midrst_food_valid", int'(food_valid), 1);
      checkOutput("midrst_busy", int'(busy), 0);
      respEn = 1'b1;

      // spawn_req coincident with reset: reset wins
      stepCycle();
      rst       = 1'b1;
      spawn_req = 1'b1;
      stepCycle();
      rst       = 1'b0;
      spawn_req = 1'b0;
      @(negedge clk);
      checkOutput("rst_wins_busy", int'(busy), 0);
      checkOutput("rst_wins_valid", int'(food_valid), 1);

`ifdef FOOD_QUERY_TIMEOUT_EN
      // Checker never answers: watchdog commits the queried cell
      respEn = 1'b0;
      applyStimulus(100, 100, 0, 0, 100, 100, 0, 0, 17, 1'b0);
      respEn = 1'b1;
`endif

      repeat (5) stepCycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
